// File: rtl/uart_word_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_word_rx_ctrl_if : byte-in / word-out stream bundle for the word RX    |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
interface uart_word_rx_ctrl_if;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic [31:0] o_Word;
    logic        o_Word_Valid;
    logic        i_Word_Ready;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Word_Ready,
        input  o_Word, o_Word_Valid
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Word_Ready,
        output o_Word, o_Word_Valid
    );
endinterface
`default_nettype wire

// File: rtl/uart_word_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_word_rx_ctrl : packs uart_rx bytes into 32-bit words behind a FWFT    |
// | FIFO; inter-byte timeout enabled by defining UART_WORD_TIMEOUT_EN.         |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module uart_word_rx_ctrl #(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_BITS = 40,
    parameter int FIFO_DEPTH   = 4,
    parameter int BIG_ENDIAN   = 0
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    uart_word_rx_ctrl_if.slave     rx_bus,
    output logic [1:0]             o_Byte_Count,
    output logic                   o_Timeout,
    output logic                   o_Overflow,
    input  logic                   i_Clear_Err
);
    localparam int c_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_count, w_count_next;
    logic [31:0] r_partial, w_partial_next, w_lane_word;
    logic        w_push, w_timeout;

    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_occ;
    logic [31:0]     r_hold;
    logic            r_overflow;
    logic            w_full, w_empty, w_pop, w_push_ok;

`ifdef UART_WORD_TIMEOUT_EN
    localparam int              c_TW   = (c_LIMIT > 1) ? $clog2(c_LIMIT) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(c_LIMIT - 1);
    logic [c_TW-1:0] r_timer;
    logic            w_timer_clr, w_timer_inc;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^c_LIMIT;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= ST_IDLE;
            r_count   <= 2'd0;
            r_partial <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_partial <= w_partial_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_partial_next = r_partial;
        w_push         = 1'b0;
        w_timeout      = 1'b0;
`ifdef UART_WORD_TIMEOUT_EN
        w_timer_clr    = 1'b0;
        w_timer_inc    = 1'b0;
`endif
        // Partial word with the incoming byte dropped into the lane for r_count
        w_lane_word = r_partial;
        for (int k = 0; k < 4; k++) begin
            if (r_count == 2'(k))
                w_lane_word[8*((BIG_ENDIAN != 0) ? 3 - k : k) +: 8] = rx_bus.i_Rx_Byte;
        end
        case (r_state)
            ST_IDLE: begin
                if (rx_bus.i_Rx_DV) begin
                    w_partial_next = w_lane_word;
                    w_count_next   = 2'd1;
                    w_state_next   = ST_ASSEMBLE;
`ifdef UART_WORD_TIMEOUT_EN
                    w_timer_clr    = 1'b1;
`endif
                end
            end
            ST_ASSEMBLE: begin
                if (rx_bus.i_Rx_DV) begin
`ifdef UART_WORD_TIMEOUT_EN
                    w_timer_clr = 1'b1;
`endif
                    if (r_count == 2'd3) begin
                        w_push         = 1'b1;
                        w_count_next   = 2'd0;
                        w_partial_next = 32'd0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_partial_next = w_lane_word;
                        w_count_next   = r_count + 2'd1;
                    end
                end else begin
`ifdef UART_WORD_TIMEOUT_EN
                    w_timer_inc = 1'b1;
                    if (r_timer == c_TMAX) begin
                        w_timeout      = 1'b1;
                        w_timer_clr    = 1'b1;
                        w_count_next   = 2'd0;
                        w_partial_next = 32'd0;
                        w_state_next   = ST_IDLE;
                    end
`endif
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef UART_WORD_TIMEOUT_EN
    // Saturating counter: parks at the limit rather than wrapping
    always_ff @(posedge i_Clock) begin
        if (i_Reset || w_timer_clr)
            r_timer <= '0;
        else if (w_timer_inc && (r_timer != c_TMAX))
            r_timer <= r_timer + c_TW'(1);
    end
`endif

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == (c_AW+1)'(FIFO_DEPTH));
    assign w_pop     = !w_empty && rx_bus.i_Word_Ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 32'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_hold     <= 32'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_lane_word;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push_ok && !w_pop)
                r_occ <= r_occ + (c_AW+1)'(1);
            else if (w_pop && !w_push_ok)
                r_occ <= r_occ - (c_AW+1)'(1);
            // A dropped word outranks a same-cycle clear
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (i_Clear_Err)
                r_overflow <= 1'b0;
        end
    end

    assign rx_bus.o_Word       = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign rx_bus.o_Word_Valid = !w_empty;
    assign o_Byte_Count        = r_count;
    assign o_Timeout           = w_timeout;
    assign o_Overflow          = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_word_rx_ctrl : directed self-checking bench, LE and BE instances   |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_uart_word_rx_ctrl;
    localparam int c_CPB   = 4;
    localparam int c_TOB   = 5;
    localparam int c_LIMIT = c_CPB * c_TOB;

    logic clk = 1'b0;
    logic rst;
    logic clr_err;
    logic [1:0] byte_count, be_byte_count;
    logic timeout, be_timeout, overflow, be_overflow;
    int n_checks = 0;
    int n_fail   = 0;

    uart_word_rx_ctrl_if bus ();
    uart_word_rx_ctrl_if bus_be ();

    assign bus_be.i_Rx_DV      = bus.i_Rx_DV;
    assign bus_be.i_Rx_Byte    = bus.i_Rx_Byte;
    assign bus_be.i_Word_Ready = bus.i_Word_Ready;

    always #5 clk = ~clk;

    uart_word_rx_ctrl #(.CLKS_PER_BIT(c_CPB), .TIMEOUT_BITS(c_TOB), .FIFO_DEPTH(4), .BIG_ENDIAN(0)) dut (
        .i_Clock(clk), .i_Reset(rst), .rx_bus(bus.slave),
        .o_Byte_Count(byte_count), .o_Timeout(timeout), .o_Overflow(overflow), .i_Clear_Err(clr_err)
    );

    uart_word_rx_ctrl #(.CLKS_PER_BIT(c_CPB), .TIMEOUT_BITS(c_TOB), .FIFO_DEPTH(4), .BIG_ENDIAN(1)) dut_be (
        .i_Clock(clk), .i_Reset(rst), .rx_bus(bus_be.slave),
        .o_Byte_Count(be_byte_count), .o_Timeout(be_timeout), .o_Overflow(be_overflow), .i_Clear_Err(clr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rdy, input logic clr);
        @(posedge clk); #1;
        bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = b; bus.i_Word_Ready = rdy; clr_err = clr;
        @(posedge clk); #1;
        bus.i_Rx_DV = 1'b0; bus.i_Word_Ready = 1'b0; clr_err = 1'b0;
    endtask

    function automatic logic [7:0] wbyte(input int i, input int k);
        return 8'(16 * i + k + 1);
    endfunction

    function automatic logic [31:0] wle(input int i);
        return {wbyte(i, 3), wbyte(i, 2), wbyte(i, 1), wbyte(i, 0)};
    endfunction

    // Four bytes of word i; ready/clear flags ride along with the last strobe
    task automatic send_word(input int i, input logic rdy, input logic clr);
        for (int k = 0; k < 3; k++) send_byte(wbyte(i, k), 1'b0, 1'b0);
        send_byte(wbyte(i, 3), rdy, clr);
    endtask

    task automatic pop_one();
        @(posedge clk); #1; bus.i_Word_Ready = 1'b1;
        @(posedge clk); #1; bus.i_Word_Ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_err = 1'b0;
        bus.i_Rx_DV = 1'b0; bus.i_Rx_Byte = 8'h00; bus.i_Word_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_valid", 32'(bus.o_Word_Valid), 32'd0);
        check_eq("rst_word", bus.o_Word, 32'd0);
        check_eq("rst_count", 32'(byte_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_to", 32'(timeout), 32'd0);

        // Little/big endian packing and one-cycle latency
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        check_eq("cnt3", 32'(byte_count), 32'd3);
        check_eq("valid_pre", 32'(bus.o_Word_Valid), 32'd0);
        send_byte(8'h44, 1'b0, 1'b0);
        check_eq("valid_post", 32'(bus.o_Word_Valid), 32'd1);
        check_eq("word_le", bus.o_Word, 32'h44332211);
        check_eq("word_be", bus_be.o_Word, 32'h11223344);
        check_eq("cnt_after", 32'(byte_count), 32'd0);
        pop_one();
        check_eq("empty_pop", 32'(bus.o_Word_Valid), 32'd0);
        check_eq("hold_word", bus.o_Word, 32'h44332211);

        // Overflow on a full FIFO, then clear
        for (int i = 1; i <= 4; i++) send_word(i, 1'b0, 1'b0);
        check_eq("ovf_before", 32'(overflow), 32'd0);
        send_word(5, 1'b0, 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        pulse_clear();
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        send_word(6, 1'b0, 1'b1);
        check_eq("ovf_setwins", 32'(overflow), 32'd1);
        pulse_clear();
        check_eq("ovf_clr2", 32'(overflow), 32'd0);
        check_eq("head_w1", bus.o_Word, wle(1));

        // Push into full FIFO with same-cycle pop
        send_word(7, 1'b1, 1'b0);
        check_eq("ovf_pushpop", 32'(overflow), 32'd0);
        check_eq("valid_pushpop", 32'(bus.o_Word_Valid), 32'd1);
        check_eq("drain0", bus.o_Word, wle(2)); pop_one();
        check_eq("drain1", bus.o_Word, wle(3)); pop_one();
        check_eq("drain2", bus.o_Word, wle(4)); pop_one();
        check_eq("drain3", bus.o_Word, wle(7)); pop_one();
        check_eq("drained", 32'(bus.o_Word_Valid), 32'd0);

        // Reset mid-assembly with a queued word
        send_word(8, 1'b0, 1'b0);
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'hE2, 1'b0, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_eq("rst_mid_cnt", 32'(byte_count), 32'd0);
        check_eq("rst_mid_valid", 32'(bus.o_Word_Valid), 32'd0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        check_eq("clean_le", bus.o_Word, 32'h88776655);
        check_eq("clean_be", bus_be.o_Word, 32'h55667788);
        pop_one();

`ifdef UART_WORD_TIMEOUT_EN
        // Byte arriving on the limit cycle beats the timeout
        send_byte(8'hAA, 1'b0, 1'b0);
        repeat (c_LIMIT - 2) @(posedge clk);
        @(posedge clk); #1; bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = 8'hBB;
        check_eq("bytewins_to", 32'(timeout), 32'd0);
        @(posedge clk); #1; bus.i_Rx_DV = 1'b0;
        check_eq("bytewins_cnt", 32'(byte_count), 32'd2);
        repeat (c_LIMIT - 2) @(posedge clk);
        #1 check_eq("to_early", 32'(timeout), 32'd0);
        @(posedge clk); #1;
        check_eq("to_pulse", 32'(timeout), 32'd1);
        check_eq("to_pulse_cnt", 32'(byte_count), 32'd2);
        @(posedge clk); #1;
        check_eq("to_end", 32'(timeout), 32'd0);
        check_eq("to_cnt0", 32'(byte_count), 32'd0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        check_eq("post_to_word", bus.o_Word, 32'h04030201);
        pop_one();
`else
        // Without the timer a partial word waits indefinitely
        begin
            logic any_to;
            any_to = 1'b0;
            send_byte(8'hAA, 1'b0, 1'b0);
            send_byte(8'hBB, 1'b0, 1'b0);
            for (int c = 0; c < 3 * c_LIMIT; c++) begin
                @(posedge clk); #1;
                any_to = any_to | timeout;
            end
            check_eq("no_to", 32'(any_to), 32'd0);
            check_eq("wait_cnt", 32'(byte_count), 32'd2);
            send_byte(8'h03, 1'b0, 1'b0);
            send_byte(8'h04, 1'b0, 1'b0);
            check_eq("late_word", bus.o_Word, 32'h0403BBAA);
            pop_one();
        end
`endif
        check_eq("final_empty", 32'(bus.o_Word_Valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
